seq_divider: RTL and testbench

- Iterative radix-2 restoring divider that receives the E-stage DIV/DIVU operands and produces the quotient and remainder that are written into LO and HI.
- It sits directly downstream of the multiply/divide issue logic, which supplies start and the operands.
- It is the team's cycle-accurate replacement for the behavioural "/" and "%" operators.
- It supports a synchronous cancel, driven by the pipeline's exception/interrupt request, so an in-flight divide is dropped without touching HI/LO.

---
 rtl/seq_divider.sv | 203 ++++++++++++++++++++
 tb/tb_seq_divider.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Iterative radix-2 restoring divider for DIV / DIVU. It produces the
//   quotient (to LO) and the remainder (to HI) one bit per cycle.
//   Sequence: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> DONE.
//   With start accepted at edge N, done is high in the cycle after edge N+34.
//
//   Quotient truncates toward zero and the remainder takes the sign of the
//   dividend. A zero divisor yields quotient = all ones and
//   remainder = original dividend.
//
//   Optional macro DIV_ZERO_FAST_EN: when defined, a zero divisor is detected
//   in PREP and the FSM skips ITER (PREP -> FIX -> DONE). When it is not
//   defined, latency is constant and FIX overrides the results instead.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   start      one-cycle request, sampled only in IDLE or DONE
//   is_signed  1 = DIV (two's complement), 0 = DIVU; captured with start
//   cancel     drops an in-flight divide; HI/LO results are left untouched
//   dividend   srcA, captured with start
//   divisor    srcB, captured with start
//   busy       high in PREP, ITER and FIX
//   done       one-cycle pulse; quotient/remainder are valid in this cycle
//   quotient   result for LO, held until the next done
//   remainder  result for HI, held until the next done
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Operands as captured with start. The raw dividend is kept because a
  // zero divisor must return the original signed value as the remainder.
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic             sgn_reg;

  // Working registers of the unsigned core.
  logic [WIDTH-1:0] abs_dvs_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [CW-1:0]    cnt_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic             div_zero_reg;

  logic             accept;
  logic             dvs_is_zero;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign accept      = start && !cancel;
  assign dvs_is_zero = (dvs_reg == '0);

  // Magnitudes. The most negative value negates to itself, which reads
  // correctly as 2^(WIDTH-1) when it is treated as unsigned.
  assign abs_dvd = (sgn_reg && dvd_reg[WIDTH-1]) ? (~dvd_reg + 1'b1) : dvd_reg;
  assign abs_dvs = (sgn_reg && dvs_reg[WIDTH-1]) ? (~dvs_reg + 1'b1) : dvs_reg;

  // One restoring step: shift {rem, quo} left, then trial-subtract. The
  // remainder stays below the divisor, so WIDTH bits hold it after the step.
  assign shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign trial   = shifted - {1'b0, abs_dvs_reg};

  // Sign fix-up, with the divide-by-zero results taking priority.
  assign q_fix = div_zero_reg ? {WIDTH{1'b1}} :
                 (q_neg_reg ? (~quo_reg + 1'b1) : quo_reg);
  assign r_fix = div_zero_reg ? dvd_reg :
                 (r_neg_reg ? (~rem_reg + 1'b1) : rem_reg);

  assign busy = (state_reg == PREP) || (state_reg == ITER) || (state_reg == FIX);
  assign done = (state_reg == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = PREP;
      end
      PREP: begin
        if (cancel) begin
          state_next = IDLE;
        end else begin
`ifdef DIV_ZERO_FAST_EN
          state_next = dvs_is_zero ? FIX : ITER;
`else
          state_next = ITER;
`endif
        end
      end
      ITER: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (cnt_reg == CW'(1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = cancel ? IDLE : DONE;
      end
      DONE: begin
        state_next = accept ? PREP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Working registers may be updated on a cancelled cycle; that is
  // harmless because only the FIX -> DONE transition writes the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_reg      <= '0;
      dvs_reg      <= '0;
      sgn_reg      <= 1'b0;
      abs_dvs_reg  <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      cnt_reg      <= '0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            dvd_reg <= dividend;
            dvs_reg <= divisor;
            sgn_reg <= is_signed;
          end
        end
        PREP: begin
          abs_dvs_reg  <= abs_dvs;
          quo_reg      <= abs_dvd;
          rem_reg      <= '0;
          cnt_reg      <= CW'(WIDTH);
          q_neg_reg    <= sgn_reg && (dvd_reg[WIDTH-1] ^ dvs_reg[WIDTH-1]);
          r_neg_reg    <= sgn_reg && dvd_reg[WIDTH-1];
          div_zero_reg <= dvs_is_zero;
        end
        ITER: begin
          if (!trial[WIDTH]) begin
            rem_reg <= trial[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= shifted[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg - CW'(1);
        end
        FIX: begin
          // Outputs load on the edge that enters DONE.
          if (!cancel) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Scoreboard bench for seq_divider. The driver pushes the expected result
//   and the expected done cycle for every accepted divide; a monitor pops and
//   compares on every done pulse and also checks that results are held
//   between pulses. Directed corner cases are followed by random operands.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic         cancel;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .cancel    (cancel),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  int           n_done = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: 64-bit integer division, so -2^31 / -1 cannot overflow;
  // the low 32 bits give the architected result.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    exp_t   e;
    longint na, nb, q, r;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      if (s) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'b0, a});
        nb = longint'({32'b0, b});
      end
      q = na / nb;
      r = na % nb;
      e.q = q[W-1:0];
      e.r = r[W-1:0];
    end
    e.due = 0;
    return e;
  endfunction

  function automatic int latency(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == '0) ? 2 : 34;
`else
    return 34;
`endif
  endfunction

  // Monitor: compare on done, otherwise require the results to be held.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_q = '0;
      last_r = '0;
    end else if (done) begin
      check("busy_low_on_done", 64'(busy), 64'(0));
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: got q=0x%0h r=0x%0h expected no done (cycle %0d)",
                 quotient, remainder, cyc);
      end else begin
        e = sb.pop_front();
        n_done++;
        $display("[TB] result %0d: q=0x%08h r=0x%08h exp q=0x%08h r=0x%08h cycle %0d due %0d",
                 n_done, quotient, remainder, e.q, e.r, cyc, e.due);
        check("quotient", 64'(quotient), 64'(e.q));
        check("remainder", 64'(remainder), 64'(e.r));
        check("done_latency", 64'(cyc), 64'(e.due));
      end
      last_q = quotient;
      last_r = remainder;
    end else begin
      check("hold_quotient", 64'(quotient), 64'(last_q));
      check("hold_remainder", 64'(remainder), 64'(last_r));
    end
  end

  // Wait for the divider to be free, then optionally idle, then issue.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                       input bit push, input int gap);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests++;
      fails++;
      $display("[TB] FAIL busy_timeout: got busy=1 expected busy=0 within 200 cycles");
    end
    repeat (gap) @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    $display("[TB] issue %s 0x%08h / 0x%08h at cycle %0d%s", s ? "DIV " : "DIVU",
             a, b, cyc, push ? "" : " (to be aborted)");
    if (push) begin
      e = model(a, b, s);
      e.due = cyc + latency(b);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    int n;
    logic [W-1:0] a, b;
    bit s;

    reset = 1'b1; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_quotient", 64'(quotient), 64'(0));
    check("reset_remainder", 64'(remainder), 64'(0));
    reset = 1'b0;

    // Unsigned basic, with busy-length measurement.
    issue(32'd100, 32'd7, 1'b0, 1'b1, 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("busy_cycles", 64'(n), 64'(34));

    // Directed corners; consecutive issues land in the DONE cycle.
    issue(-32'sd7, 32'd2, 1'b1, 1'b1, 0);
    issue(32'd7, -32'sd2, 1'b1, 1'b1, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
    issue(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
    issue(32'h1234_5678, 32'h0, 1'b1, 1'b1, 0);
    issue(32'h1234_5678, 32'h0, 1'b0, 1'b1, 1);
    issue(32'hFFFF_FFF0, 32'h0, 1'b1, 1'b1, 0);
    drain();

    // Cancel mid-ITER: no done, previous results held.
    issue(32'd50, 32'd5, 1'b0, 1'b0, 2);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy_low", 64'(busy), 64'(0));
    repeat (40) @(negedge clk);
    check("cancel_keeps_q", 64'(quotient), 64'(32'hFFFF_FFFF));
    check("cancel_keeps_r", 64'(remainder), 64'(32'hFFFF_FFF0));
    issue(32'd50, 32'd5, 1'b0, 1'b1, 0);
    drain();

    // start together with cancel in IDLE is ignored.
    @(negedge clk);
    dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
    start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("start_with_cancel_ignored", 64'(busy), 64'(0));
    repeat (40) @(negedge clk);

    // Random operands with random idle gaps (0 = back-to-back).
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 20));
        2: b = -W'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      issue(a, b, s, 1'b1, $urandom_range(0, 2));
    end
    drain();

    // Reset mid-ITER clears everything on the next cycle.
    issue(32'd1000, 32'd3, 1'b1, 1'b0, 1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_done", 64'(done), 64'(0));
    check("midreset_quotient", 64'(quotient), 64'(0));
    check("midreset_remainder", 64'(remainder), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    issue(-32'sd1000, 32'd3, 1'b1, 1'b1, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
